// File: rtl/xadc_drp_arbiter_if.sv
// ---------------------------------------------------------------------------------------------
// xadc_drp_arbiter_if
//
// Bundles every signal the DRP arbiter exchanges with the outside world, except clock and reset.
//   Requester 0/1 : reqN, weN, addrN, wdataN (to arbiter); ackN, errN, rdataN (from arbiter)
//   XADC DRP      : DADDR, DEN, DWE, DI (to XADC); DO, DRDY (from XADC)
//   Status        : busy, grant, timeout_flag (from arbiter)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus the XADC primitive)
// ---------------------------------------------------------------------------------------------
interface xadc_drp_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 16
);
    // Requester 0 (channel poller)
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  ack0;
    logic                  err0;
    logic [DATA_WIDTH-1:0] rdata0;

    // Requester 1 (AXI host path)
    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack1;
    logic                  err1;
    logic [DATA_WIDTH-1:0] rdata1;

    // XADC DRP
    logic [ADDR_WIDTH-1:0] DADDR;
    logic                  DEN;
    logic                  DWE;
    logic [DATA_WIDTH-1:0] DI;
    logic [DATA_WIDTH-1:0] DO;
    logic                  DRDY;

    // Status
    logic                  busy;
    logic [1:0]            grant;
    logic                  timeout_flag;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  DO, DRDY,
        output ack0, err0, rdata0,
        output ack1, err1, rdata1,
        output DADDR, DEN, DWE, DI,
        output busy, grant, timeout_flag
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output DO, DRDY,
        input  ack0, err0, rdata0,
        input  ack1, err1, rdata1,
        input  DADDR, DEN, DWE, DI,
        input  busy, grant, timeout_flag
    );
endinterface

// File: rtl/xadc_drp_arbiter.sv
// ---------------------------------------------------------------------------------------------
// xadc_drp_arbiter
//
// Shares the single XADC DRP between two requesters (0 = channel poller, 1 = AXI host path).
// One DRP read or write is sequenced at a time (IDLE -> ISSUE -> WAIT -> DONE), ties are broken
// round-robin, and a DRDY timeout bounds how long a hung XADC can hold the port.
//
// Ports:
//   clk    - DRP/AXI clock, rising edge
//   rst    - asynchronous active-high reset
//   arb_io - slave modport of xadc_drp_arbiter_if (requester handshakes, DRP pins, status)
// ---------------------------------------------------------------------------------------------
module xadc_drp_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst,
    xadc_drp_arbiter_if.slave   arb_io
);

    // Last WAIT cycle count before the transaction is abandoned.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;  // index of the previous winner
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic                  dwe_q, dwe_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  tflag_q, tflag_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic any_req;
    logic win1;
    logic timeout_hit;

    assign any_req     = arb_io.req0 | arb_io.req1;
    // On a tie the requester that did not win last time takes the port.
    assign win1        = arb_io.req1 & (~arb_io.req0 | ~last_grant_q);
    assign timeout_hit = (cnt_q == TimeoutLast);

    // -----------------------------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (arb_io.DRDY || timeout_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        daddr_d      = daddr_q;
        di_d         = di_q;
        dwe_d        = dwe_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        tflag_d      = tflag_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d      = win1 ? 2'b10 : 2'b01;
                    last_grant_d = win1;
                    daddr_d      = win1 ? arb_io.addr1  : arb_io.addr0;
                    di_d         = win1 ? arb_io.wdata1 : arb_io.wdata0;
                    dwe_d        = win1 ? arb_io.we1    : arb_io.we0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                // DRDY takes priority over a timeout landing in the same cycle.
                if (arb_io.DRDY) begin
                    err_d = 1'b0;
                    if (!dwe_q) begin
                        if (grant_q[1]) rdata1_d = arb_io.DO;
                        else            rdata0_d = arb_io.DO;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    tflag_d = 1'b1;
                    if (grant_q[1]) rdata1_d = '1;
                    else            rdata0_d = '1;
                end
            end
            StDone: begin
                cnt_d = '0;
                err_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            daddr_q      <= '0;
            di_q         <= '0;
            dwe_q        <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            tflag_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            daddr_q      <= daddr_d;
            di_q         <= di_d;
            dwe_q        <= dwe_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            tflag_q      <= tflag_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs: decoded from the state register so reset clears strobes without a clock edge
    // -----------------------------------------------------------------------------------------
    always_comb begin
        arb_io.DEN          = 1'b0;
        arb_io.DWE          = 1'b0;
        arb_io.busy         = 1'b1;
        arb_io.grant        = grant_q;
        arb_io.ack0         = 1'b0;
        arb_io.ack1         = 1'b0;
        arb_io.err0         = 1'b0;
        arb_io.err1         = 1'b0;
        arb_io.DADDR        = daddr_q;
        arb_io.DI           = di_q;
        arb_io.rdata0       = rdata0_q;
        arb_io.rdata1       = rdata1_q;
        arb_io.timeout_flag = tflag_q;
        unique case (state_q)
            StIdle: begin
                arb_io.busy  = 1'b0;
                arb_io.grant = 2'b00;
            end
            StIssue: begin
                arb_io.DEN = 1'b1;
                arb_io.DWE = dwe_q;
            end
            StDone: begin
                arb_io.ack0 = grant_q[0];
                arb_io.ack1 = grant_q[1];
                arb_io.err0 = grant_q[0] & err_q;
                arb_io.err1 = grant_q[1] & err_q;
            end
            default: ;
        endcase
    end

endmodule
